fft_result_reader: RTL and testbench
====================================

Name: fft_result_reader

Overview:
- Unloads a finished transform from the four fft_top result banks once the core signals ready.
- Reads the banks through fft_top's four iADDR_RD_x / oDATA_RE_x port pairs.
- Streams the real parts out as one sample per beat with a valid/ready handshake, in natural or bit-reversed bin order.
- Read side of the sample-load path: the loader writes iADDR_WR_x/iWE_x; this block reads iADDR_RD_x/oDATA_RE_x.

Parameters:
DATA_W, 16, width of one result word (signed)
ADDR_W, 9, per-bank address width (512 words/bank)
BANKS, 4, number of banks (fixed to 4; the bank index is 2 bits)
RD_LAT, 2, cycles from address out to valid data in (registered altsyncram output)
BITREV, 0, 0 = natural bin order, 1 = bit-reversed bin order

Ports:
iCLK  in  1  clock
iRESET  in  1  asynchronous reset, active-high
iSTART  in  1  one-cycle arm request
iABORT  in  1  synchronous flush, returns to IDLE
iFFT_RDY  in  1  fft_top oRDY (level)
oADDR_RD_0..3  out  ADDR_W each  bank read addresses to fft_top
iDATA_RE_0..3  in  DATA_W each  bank read data from fft_top
oDATA  out  DATA_W  stream data
oBIN  out  ADDR_W+2  bin index of oDATA
oVALID  out  1  stream valid
iREADY  in  1  stream ready
oLAST  out  1  high with bin 2047
oBUSY  out  1  high in any state except IDLE
oDONE  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset values: all oADDR_RD_x = 0, oDATA = 0, oBIN = 0, oVALID = 0, oLAST = 0, oBUSY = 0, oDONE = 0, state = IDLE, counters = 0, FIFO empty. Reset is asynchronous and active-high, and takes effect mid-operation with no pending output.
- Total points N = BANKS * 2^ADDR_W = 2048.
- Bin k (11 bits) gives index m = BITREV ? bitreverse11(k) : k.
  - Bank = m[10:9].
  - Address = m[8:0].
- All four oADDR_RD_x carry the same address.
- The bank select is delayed RD_LAT cycles and then muxes iDATA_RE_x into the output FIFO, together with the delayed k.
- State IDLE:
  - iSTART goes to WAIT_RDY.
  - iSTART in any other state is ignored.
- State WAIT_RDY: iFFT_RDY == 1 goes to READ, with the issue counter k = 0.
- State READ:
  - Issue one read per cycle only while fifo_count + inflight < FIFO_DEPTH.
  - FIFO_DEPTH = RD_LAT + 2.
  - inflight counts issued reads not yet written into the FIFO.
  - When k = 2047 is issued, go to DRAIN.
- State DRAIN: when inflight = 0, the FIFO is empty and the last handshake is complete, go to IDLE and pulse oDONE for one cycle.
- Stream rules:
  - oVALID = FIFO not empty.
  - A beat transfers on oVALID & iREADY.
  - oDATA, oBIN and oLAST hold stable while oVALID & !iREADY.
  - No drops, no duplicates.
- Throughput: with iREADY held at 1, exactly one beat per cycle after the first.
  - First oVALID appears RD_LAT+1 cycles after entry to READ.
- Data is passed through unmodified, sign preserved, with no scaling.
- iABORT (any state, priority over iSTART):
  - Next cycle: FIFO flushed, oVALID = 0, inflight discarded, state IDLE.
  - No oDONE.
  - Addresses hold their last value.
- iFFT_RDY dropping during READ or DRAIN is ignored; the unload completes.
- Counter wrap: k saturates at 2047. It does not wrap into a second pass.

Decomposition:
- Package fft_rd_pkg holds:
  - The state enum (IDLE, WAIT_RDY, READ, DRAIN).
  - N_POINTS = 2048.
  - BIN_W = 11.
  - The bitreverse function.
- Sub-module fft_rd_fifo: small synchronous FIFO, depth RD_LAT+2, width DATA_W+BIN_W+1, with count output. It holds data, bin and last.

Test Plan:
- Setup for all scenarios: bank model returns bank*1000 + addr with RD_LAT = 2.
- Natural order, iREADY = 1:
  - Expect 2048 beats.
  - Beat k has oDATA = (k>>9)*1000 + (k&511): k=0 gives 0, k=513 gives 1001, k=2047 gives 3511.
  - oLAST only at beat 2047.
  - oDONE the cycle after the last beat.
  - Total time: entry to READ through last beat = 2048 + RD_LAT cycles.
- Random 50% iREADY: same 2048-value sequence. The checker flags any drop, duplicate, or change of oDATA/oBIN while stalled.
- BITREV = 1:
  - Beat 0 gives 0.
  - Beat 1 (m = 1024) gives 2000.
  - Beat 2 (m = 512) gives 1000.
  - Beat 3 (m = 1536) gives 3000.
  - Beat 2047 gives 3511.
- iSTART with iFFT_RDY = 0 for 50 cycles:
  - oADDR_RD_x stay at 0, no oVALID, oBUSY = 1.
  - Raising iFFT_RDY starts the reads.
  - A second iSTART while busy has no effect.
- iABORT at the handshake of beat 700:
  - oVALID = 0 next cycle, state IDLE, no oDONE.
  - A new iSTART with iFFT_RDY = 1 restarts at bin 0, oDATA = 0.
- Assert iRESET asynchronously mid-stream (between clock edges):
  - All outputs reach their reset values before the next edge.
  - After release, operation is normal from IDLE.

Source files
------------

// File: rtl/fft_rd_pkg.sv
// fft_rd_pkg: shared types and helpers for the FFT result reader.
//   N_POINTS  - total transform length (4 banks x 512 words)
//   BIN_W     - width of a bin index
//   rd_state_e - unload controller states
//   rd_tag_t  - bookkeeping carried alongside each outstanding bank read
//   bitrev    - bit-reverse an 11-bit bin index
package fft_rd_pkg;

  localparam int N_POINTS = 2048;
  localparam int BIN_W    = 11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RDY,
    READ,
    DRAIN
  } rd_state_e;

  typedef struct packed {
    logic             vld;
    logic [1:0]       bank;
    logic [BIN_W-1:0] bin;
    logic             last;
  } rd_tag_t;

  function automatic logic [BIN_W-1:0] bitrev(input logic [BIN_W-1:0] x);
    logic [BIN_W-1:0] r;
    r = '0;
    for (int i = 0; i < BIN_W; i++) begin
      r[i] = x[BIN_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_rd_fifo.sv
// fft_rd_fifo: small register-based synchronous FIFO with occupancy count.
//   clk_i, rst_i  - clock, asynchronous active-high reset
//   flush_i       - synchronous clear of all entries (wins over push)
//   push_i/wdata_i - write one entry
//   pop_i         - remove the head entry (ignored when empty)
//   rdata_o       - head entry, valid whenever count_o != 0
//   count_o       - number of stored entries
module fft_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it while count_q is zero.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fft_result_reader.sv
// fft_result_reader: unloads a finished transform from the four fft_top
// result banks and streams the real parts out, one sample per beat.
//   iCLK, iRESET        - clock, asynchronous active-high reset
//   iSTART              - arm request (honoured in IDLE only)
//   iABORT              - synchronous flush back to IDLE, no oDONE
//   iFFT_RDY            - core ready level; starts the unload from WAIT_RDY
//   oADDR_RD_0..3       - common read address to all four banks
//   iDATA_RE_0..3       - bank read data, RD_LAT cycles after the address
//   oDATA/oBIN/oLAST    - stream payload, bin index and final-bin flag
//   oVALID/iREADY       - stream handshake
//   oBUSY               - controller not in IDLE
//   oDONE               - one-cycle pulse after the final handshake
module fft_result_reader
  import fft_rd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int BANKS  = 4,
  parameter int RD_LAT = 2,
  parameter int BITREV = 0
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iABORT,
  input  logic              iFFT_RDY,
  output logic [ADDR_W-1:0] oADDR_RD_0,
  output logic [ADDR_W-1:0] oADDR_RD_1,
  output logic [ADDR_W-1:0] oADDR_RD_2,
  output logic [ADDR_W-1:0] oADDR_RD_3,
  input  logic [DATA_W-1:0] iDATA_RE_0,
  input  logic [DATA_W-1:0] iDATA_RE_1,
  input  logic [DATA_W-1:0] iDATA_RE_2,
  input  logic [DATA_W-1:0] iDATA_RE_3,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W+1:0] oBIN,
  output logic              oVALID,
  input  logic              iREADY,
  output logic              oLAST,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int FIFO_W     = DATA_W + BIN_W + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BANKS * (2 ** ADDR_W) - 1);

  rd_state_e         state_q;
  logic [BIN_W-1:0]  k_q;          // next bin to issue while in READ
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  inflight_q;
  logic              done_q;
  rd_tag_t           pipe_q [RD_LAT+1];

  logic [CNT_W-1:0]  fifo_count;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [FIFO_W-1:0] fifo_wdata;
  logic              fifo_push, pop, issue, drain_done;
  logic [CNT_W:0]    occ_d;
  logic [BIN_W-1:0]  issue_bin_d, issue_m_d;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] head_data;
  logic [BIN_W-1:0]  head_bin;
  logic              head_last;

  always_comb begin
    pop = (fifo_count != '0) && iREADY;
    // Occupancy after this cycle's pop: every outstanding read already owns
    // a slot, so issuing against this keeps the FIFO from overflowing while
    // still allowing one issue per cycle when the consumer keeps up.
    occ_d = {1'b0, fifo_count} + {1'b0, inflight_q} - (CNT_W+1)'(pop);
    // Bin 0 goes out on the WAIT_RDY->READ edge so the first beat is not
    // delayed by an extra cycle.
    issue_bin_d = (state_q == WAIT_RDY) ? '0 : k_q;
    issue_m_d   = (BITREV != 0) ? bitrev(issue_bin_d) : issue_bin_d;
    issue = !iABORT &&
            (((state_q == WAIT_RDY) && iFFT_RDY) ||
             ((state_q == READ) && (occ_d < (CNT_W+1)'(FIFO_DEPTH))));
    // Finishing when the final beat hands off lets oDONE land the next cycle.
    drain_done = (state_q == DRAIN) && (inflight_q == '0) &&
                 (fifo_count == CNT_W'(pop));
  end

  // Controller: state, issue counter, address, in-flight count, done pulse.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q    <= IDLE;
      k_q        <= '0;
      addr_q     <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (issue) addr_q <= issue_m_d[ADDR_W-1:0];
      if (iABORT) begin
        state_q    <= IDLE;
        inflight_q <= '0;
      end else begin
        inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(fifo_push);
        case (state_q)
          IDLE: begin
            if (iSTART) state_q <= WAIT_RDY;
          end
          WAIT_RDY: begin
            if (iFFT_RDY) begin
              state_q <= READ;
              k_q     <= BIN_W'(1);
            end
          end
          READ: begin
            if (issue) begin
              // k stops at the final bin; the transform is read exactly once.
              if (k_q == LAST_BIN) state_q <= DRAIN;
              else                 k_q     <= k_q + 1'b1;
            end
          end
          DRAIN: begin
            if (drain_done) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Tag pipeline matched to the bank read latency: stage RD_LAT lines up
  // with the data on iDATA_RE_x.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
    end else if (iABORT) begin
      for (int i = 0; i <= RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0].vld  <= issue;
      pipe_q[0].bank <= issue_m_d[BIN_W-1:ADDR_W];
      pipe_q[0].bin  <= issue_bin_d;
      pipe_q[0].last <= (issue_bin_d == LAST_BIN);
      for (int i = 1; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    rd_data = iDATA_RE_0;
    case (pipe_q[RD_LAT].bank)
      2'd0:    rd_data = iDATA_RE_0;
      2'd1:    rd_data = iDATA_RE_1;
      2'd2:    rd_data = iDATA_RE_2;
      default: rd_data = iDATA_RE_3;
    endcase
  end

  assign fifo_push  = pipe_q[RD_LAT].vld;
  assign fifo_wdata = {rd_data, pipe_q[RD_LAT].bin, pipe_q[RD_LAT].last};

  fft_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_i   (iRESET),
    .flush_i (iABORT),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign {head_data, head_bin, head_last} = fifo_rdata;

  // Payload is forced to zero when nothing is valid so idle/reset outputs
  // never show stale FIFO contents.
  assign oVALID = (fifo_count != '0);
  assign oDATA  = oVALID ? head_data : '0;
  assign oBIN   = oVALID ? head_bin  : '0;
  assign oLAST  = oVALID & head_last;
  assign oBUSY  = (state_q != IDLE);
  assign oDONE  = done_q;

  assign oADDR_RD_0 = addr_q;
  assign oADDR_RD_1 = addr_q;
  assign oADDR_RD_2 = addr_q;
  assign oADDR_RD_3 = addr_q;

endmodule

// File: tb/tb_fft_result_reader.sv
module tb_fft_result_reader;

  logic iCLK = 1'b0;
  logic iRESET, iSTART, iABORT, iFFT_RDY, iREADY;

  logic [8:0]  addr_rd [2][4];
  logic [8:0]  a1      [2][4];
  logic [15:0] data_re [2][4];
  logic [15:0] o_data  [2];
  logic [10:0] o_bin   [2];
  logic        o_valid [2];
  logic        o_last  [2];
  logic        o_busy  [2];
  logic        o_done  [2];

  always #5 iCLK = ~iCLK;

  // Instance 0: natural order, instance 1: bit-reversed order; same controls.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    fft_result_reader #(
      .DATA_W(16), .ADDR_W(9), .BANKS(4), .RD_LAT(2), .BITREV(gi)
    ) u_dut (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .iSTART     (iSTART),
      .iABORT     (iABORT),
      .iFFT_RDY   (iFFT_RDY),
      .oADDR_RD_0 (addr_rd[gi][0]),
      .oADDR_RD_1 (addr_rd[gi][1]),
      .oADDR_RD_2 (addr_rd[gi][2]),
      .oADDR_RD_3 (addr_rd[gi][3]),
      .iDATA_RE_0 (data_re[gi][0]),
      .iDATA_RE_1 (data_re[gi][1]),
      .iDATA_RE_2 (data_re[gi][2]),
      .iDATA_RE_3 (data_re[gi][3]),
      .oDATA      (o_data[gi]),
      .oBIN       (o_bin[gi]),
      .oVALID     (o_valid[gi]),
      .iREADY     (iREADY),
      .oLAST      (o_last[gi]),
      .oBUSY      (o_busy[gi]),
      .oDONE      (o_done[gi])
    );
  end

  // Bank model: word = bank*1000 + addr, two-cycle read latency.
  always @(posedge iCLK) begin
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) begin
        a1[b][j]      <= addr_rd[b][j];
        data_re[b][j] <= 16'(j * 1000 + int'(a1[b][j]));
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_ready = 0;

  int exp_idx [2];
  int first_valid [2];
  int last_hs [2];
  bit done_seen [2];
  bit stall [2];
  bit hs_now [2];
  int hs_bin [2];
  logic [15:0] held_data [2];
  logic [10:0] held_bin [2];
  logic        held_last [2];
  int cap [2][2048];

  typedef struct {
    int inst;
    int beat;
    int exp_data;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input bit ok, input string name, input int inst,
                       input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d, expected %0d (cycle %0d)",
               name, inst, act, exp, cyc);
    end
  endtask

  // Reference: beat n of instance b reads index m, bank m/512, address m%512.
  function automatic int rev11(input int n);
    int r = 0;
    for (int i = 0; i < 11; i++) if ((n >> i) & 1) r += 1 << (10 - i);
    return r;
  endfunction

  function automatic int exp_word(input int b, input int n);
    int m = (b == 1) ? rev11(n) : n;
    return (m / 512) * 1000 + (m % 512);
  endfunction

  task automatic check_reset_vals();
    for (int b = 0; b < 2; b++) begin
      check(o_valid[b] == 1'b0, "rst oVALID", b, int'(o_valid[b]), 0);
      check(o_data[b] == 16'd0, "rst oDATA", b, int'(o_data[b]), 0);
      check(o_bin[b] == 11'd0, "rst oBIN", b, int'(o_bin[b]), 0);
      check(o_last[b] == 1'b0, "rst oLAST", b, int'(o_last[b]), 0);
      check(o_busy[b] == 1'b0, "rst oBUSY", b, int'(o_busy[b]), 0);
      check(o_done[b] == 1'b0, "rst oDONE", b, int'(o_done[b]), 0);
      for (int j = 0; j < 4; j++)
        check(addr_rd[b][j] == 9'd0, "rst oADDR", b, int'(addr_rd[b][j]), 0);
    end
  endtask

  task automatic clear_monitor();
    for (int b = 0; b < 2; b++) begin
      exp_idx[b] = 0; first_valid[b] = -1; done_seen[b] = 0;
      stall[b] = 0; hs_now[b] = 0; last_hs[b] = -10;
    end
  endtask

  // One cycle: sample at negedge, check, then drive inputs for the next edge.
  task automatic step();
    @(negedge iCLK);
    cyc++;
    iSTART = 1'b0;
    iABORT = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (stall[b])
        check(o_valid[b] && o_data[b] == held_data[b] && o_bin[b] == held_bin[b]
              && o_last[b] == held_last[b], "hold while stalled", b,
              int'(o_data[b]), int'(held_data[b]));
      check(o_done[b] == (last_hs[b] == cyc - 1), "oDONE", b,
            int'(o_done[b]), int'(last_hs[b] == cyc - 1));
      if (o_done[b]) done_seen[b] = 1;
      if (o_valid[b] && first_valid[b] < 0) first_valid[b] = cyc;
    end
    iREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int b = 0; b < 2; b++) begin
      hs_now[b] = o_valid[b] && iREADY;
      hs_bin[b] = int'(o_bin[b]);
      if (hs_now[b]) begin
        if (exp_idx[b] >= 2048) begin
          check(1'b0, "extra beat", b, int'(o_bin[b]), -1);
        end else begin
          check(o_data[b] == 16'(exp_word(b, exp_idx[b])), "oDATA", b,
                int'(o_data[b]), exp_word(b, exp_idx[b]));
          check(o_bin[b] == 11'(exp_idx[b]), "oBIN", b, int'(o_bin[b]), exp_idx[b]);
          check(o_last[b] == (exp_idx[b] == 2047), "oLAST", b,
                int'(o_last[b]), int'(exp_idx[b] == 2047));
          cap[b][exp_idx[b]] = int'(o_data[b]);
          if (exp_idx[b] == 2047) last_hs[b] = cyc;
          exp_idx[b]++;
        end
      end
      stall[b]     = o_valid[b] && !iREADY;
      held_data[b] = o_data[b];
      held_bin[b]  = o_bin[b];
      held_last[b] = o_last[b];
    end
  endtask

  task automatic begin_run();
    clear_monitor();
    iSTART   = 1'b1;
    iFFT_RDY = 1'b1;
  endtask

  task automatic run_unload(input int drop_at);
    int t0 = cyc;
    while (!(done_seen[0] && done_seen[1])) begin
      if (cyc - t0 > 8000) begin
        check(1'b0, "unload timeout", 0, cyc - t0, 8000);
        break;
      end
      step();
      if (drop_at >= 0 && cyc - t0 == drop_at) iFFT_RDY = 1'b0;
    end
    for (int b = 0; b < 2; b++) check(exp_idx[b] == 2048, "beat count", b, exp_idx[b], 2048);
  endtask

  initial begin
    int entry;
    bit hit;
    logic [8:0] addr_hold [2];

    tbl[0] = '{0, 0, 0};
    tbl[1] = '{0, 513, 1001};
    tbl[2] = '{0, 2047, 3511};
    tbl[3] = '{1, 0, 0};
    tbl[4] = '{1, 1, 2000};
    tbl[5] = '{1, 2, 1000};
    tbl[6] = '{1, 3, 3000};
    tbl[7] = '{1, 2047, 3511};

    iRESET = 1'b1; iSTART = 1'b0; iABORT = 1'b0; iFFT_RDY = 1'b0; iREADY = 1'b1;
    clear_monitor();
    repeat (2) @(negedge iCLK);
    check_reset_vals();
    iRESET = 1'b0;

    // Armed but core not ready: nothing moves for 50 cycles.
    step();
    clear_monitor();
    iSTART = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (i == 25) iSTART = 1'b1;   // second arm while busy
      for (int b = 0; b < 2; b++) begin
        check(addr_rd[b][0] == 9'd0 && addr_rd[b][1] == 9'd0 && addr_rd[b][2] == 9'd0
              && addr_rd[b][3] == 9'd0, "wait oADDR", b, int'(addr_rd[b][0]), 0);
        check(o_valid[b] == 1'b0, "wait oVALID", b, int'(o_valid[b]), 0);
        check(o_busy[b] == 1'b1, "wait oBUSY", b, int'(o_busy[b]), 1);
      end
    end

    // Full-rate unload, natural and bit-reversed in parallel.
    iFFT_RDY = 1'b1;
    entry = cyc + 1;
    rand_ready = 0;
    run_unload(-1);
    for (int b = 0; b < 2; b++) begin
      check(first_valid[b] - entry == 3, "first oVALID latency", b, first_valid[b] - entry, 3);
      check(last_hs[b] - entry == 2050, "last beat time", b, last_hs[b] - entry, 2050);
      check(o_busy[b] == 1'b0, "idle after done", b, int'(o_busy[b]), 0);
    end
    for (int i = 0; i < 8; i++)
      check(cap[tbl[i].inst][tbl[i].beat] == tbl[i].exp_data, "spot beat", tbl[i].inst,
            cap[tbl[i].inst][tbl[i].beat], tbl[i].exp_data);

    // Random backpressure; core ready drops mid-unload and is ignored.
    step();
    begin_run();
    rand_ready = 1;
    run_unload(100);

    // Abort on the handshake of beat 700, then restart from bin 0.
    step();
    begin_run();
    rand_ready = 0;
    hit = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      step();
      if (hs_now[0] && hs_bin[0] == 700) begin
        iABORT = 1'b1;
        hit = 1;
        for (int b = 0; b < 2; b++) addr_hold[b] = addr_rd[b][0];
      end
    end
    check(hit, "reached beat 700", 0, int'(hit), 1);
    step();
    for (int b = 0; b < 2; b++) begin
      check(o_valid[b] == 1'b0, "abort oVALID", b, int'(o_valid[b]), 0);
      check(o_busy[b] == 1'b0, "abort oBUSY", b, int'(o_busy[b]), 0);
      check(addr_rd[b][0] == addr_hold[b], "abort addr hold", b,
            int'(addr_rd[b][0]), int'(addr_hold[b]));
    end
    repeat (5) step();
    begin_run();
    run_unload(-1);

    // Asynchronous reset between clock edges in the middle of a stream.
    step();
    begin_run();
    rand_ready = 1;
    repeat (300) step();
    @(posedge iCLK);
    #2 iRESET = 1'b1;
    #1 check_reset_vals();
    @(negedge iCLK);
    iRESET = 1'b0;
    clear_monitor();
    begin_run();
    run_unload(-1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
